// File: rtl/latch_report_tx.sv
// Host-side reporter for a two-register latching counter: frames each latched value as
// tag + counter bytes toward the USB FIFO and answers host acks with a reset-latch pulse.
module latch_report_tx #(
    parameter int pWIDTH       = 40,
    parameter int pPULSE       = 4,
    parameter int pACK_TIMEOUT = 0
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [pWIDTH-1:0] iCOUNTER,
    input  logic              iRdyCOUNTER,
    input  logic [pWIDTH-1:0] iCOUNTER2,
    input  logic              iRdyCOUNTER2,
    output logic [7:0]        oTxData,
    output logic              oTxValid,
    input  logic              iTxReady,
    input  logic [7:0]        iRxData,
    input  logic              iRxValid,
    output logic              oRxReady,
    output logic              oResetLatch1,
    output logic              oResetLatch2,
    output logic              oBusy,
    output logic [7:0]        oErrCount
);

    localparam int pBYTES = pWIDTH / 8;
    localparam int IW     = (pBYTES > 1) ? $clog2(pBYTES) : 1;
    localparam int TW     = (pACK_TIMEOUT > 1) ? $clog2(pACK_TIMEOUT + 1) : 1;
    localparam int PW     = (pPULSE > 1) ? $clog2(pPULSE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        DATA,
        WAIT_ACK,
        PULSE
    } state_t;

    state_t            state_q, state_d;
    logic              rdy1Meta_q, rdyS1_q, rdy2Meta_q, rdyS2_q;
    logic              served1_q, served1_d, served2_q, served2_d;
    logic              chan_q, chan_d;
    logic              lastChan_q, lastChan_d;
    logic [pWIDTH-1:0] shadow_q, shadow_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PW-1:0]     pulseCnt_q, pulseCnt_d;
    logic [7:0]        errCount_q, errCount_d;
    logic              rxReady_q;

    logic              elig1, elig2, grant2, ackHit;
    logic [7:0]        tag, dataByte;

    assign tag    = {7'b0, chan_q};
    assign elig1  = rdyS1_q && !served1_q;
    assign elig2  = rdyS2_q && !served2_q;
    assign ackHit = (state_q == WAIT_ACK) && iRxValid && (iRxData == tag);

    always_comb begin
        dataByte = shadow_q[7:0];
        for (int b = 0; b < pBYTES; b++) begin
            if (idx_q == IW'(b)) dataByte = shadow_q[8*b +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        served1_d    = served1_q;
        served2_d    = served2_q;
        chan_d       = chan_q;
        lastChan_d   = lastChan_q;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        pulseCnt_d   = pulseCnt_q;
        errCount_d   = errCount_q;
        grant2       = 1'b0;
        oTxValid     = 1'b0;
        oTxData      = 8'h00;
        oResetLatch1 = 1'b0;
        oResetLatch2 = 1'b0;

        // A low Rdy re-arms the channel; a matching ack marks it served until then.
        if (!rdyS1_q)                served1_d = 1'b0;
        else if (ackHit && !chan_q)  served1_d = 1'b1;
        if (!rdyS2_q)                served2_d = 1'b0;
        else if (ackHit && chan_q)   served2_d = 1'b1;

        if (iRxValid && !ackHit && errCount_q != 8'hFF) errCount_d = errCount_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (elig1 || elig2) begin
                    grant2     = elig2 && (!elig1 || !lastChan_q);
                    chan_d     = grant2;
                    lastChan_d = grant2;
                    shadow_d   = grant2 ? iCOUNTER2 : iCOUNTER;
                    state_d    = TAG;
                end
            end
            TAG: begin
                oTxValid = 1'b1;
                oTxData  = tag;
                if (iTxReady) begin
                    state_d = DATA;
                    idx_d   = IW'(pBYTES - 1);
                end
            end
            DATA: begin
                oTxValid = 1'b1;
                oTxData  = dataByte;
                if (iTxReady) begin
                    if (idx_q == '0) begin
                        state_d = WAIT_ACK;
                        timer_d = '0;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                timer_d = timer_q + 1'b1;
                if (ackHit) begin
                    state_d    = PULSE;
                    pulseCnt_d = '0;
                end else if (pACK_TIMEOUT != 0 && timer_q == TW'(pACK_TIMEOUT - 1)) begin
                    state_d = TAG;
                    timer_d = '0;
                end
            end
            PULSE: begin
                oResetLatch1 = !chan_q;
                oResetLatch2 = chan_q;
                pulseCnt_d   = pulseCnt_q + 1'b1;
                if (pulseCnt_q == PW'(pPULSE - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q    <= IDLE;
            rdy1Meta_q <= 1'b0;
            rdyS1_q    <= 1'b0;
            rdy2Meta_q <= 1'b0;
            rdyS2_q    <= 1'b0;
            served1_q  <= 1'b0;
            served2_q  <= 1'b0;
            chan_q     <= 1'b0;
            lastChan_q <= 1'b1;
            shadow_q   <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            pulseCnt_q <= '0;
            errCount_q <= 8'h00;
            rxReady_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy1Meta_q <= iRdyCOUNTER;
            rdyS1_q    <= rdy1Meta_q;
            rdy2Meta_q <= iRdyCOUNTER2;
            rdyS2_q    <= rdy2Meta_q;
            served1_q  <= served1_d;
            served2_q  <= served2_d;
            chan_q     <= chan_d;
            lastChan_q <= lastChan_d;
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            pulseCnt_q <= pulseCnt_d;
            errCount_q <= errCount_d;
            rxReady_q  <= 1'b1;
        end
    end

    assign oBusy     = (state_q != IDLE);
    assign oErrCount = errCount_q;
    assign oRxReady  = rxReady_q;

endmodule

// File: tb/tb_latch_report_tx.sv
// Self-checking bench for latch_report_tx: a table-driven first frame plus hand-written
// sequences for stalls, arbitration, ack timeout, mid-frame reset and error saturation.
module tb_latch_report_tx;

    logic        clk;
    logic        rstN;
    logic [39:0] counter1, counter2;
    logic        rdy1, rdy2;
    logic [7:0]  txData;
    logic        txValid, txReady;
    logic [7:0]  rxData;
    logic        rxValid, rxReady;
    logic        latch1, latch2, busy;
    logic [7:0]  errCount;

    int checks   = 0;
    int failures = 0;

    latch_report_tx #(
        .pWIDTH      (40),
        .pPULSE      (4),
        .pACK_TIMEOUT(16)
    ) dut (
        .iCLK        (clk),
        .iRST_N      (rstN),
        .iCOUNTER    (counter1),
        .iRdyCOUNTER (rdy1),
        .iCOUNTER2   (counter2),
        .iRdyCOUNTER2(rdy2),
        .oTxData     (txData),
        .oTxValid    (txValid),
        .iTxReady    (txReady),
        .iRxData     (rxData),
        .iRxValid    (rxValid),
        .oRxReady    (rxReady),
        .oResetLatch1(latch1),
        .oResetLatch2(latch2),
        .oBusy       (busy),
        .oErrCount   (errCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rdy1;
        logic       rdy2;
        logic       txReady;
        logic       rxValid;
        logic [7:0] rxData;
        logic       expValid;
        logic [7:0] expData;
        logic       expL1;
        logic       expL2;
        logic       expBusy;
    } vec_t;

    vec_t vecs[17];

    task automatic applyStimulus(input vec_t v);
        rdy1    = v.rdy1;
        rdy2    = v.rdy2;
        txReady = v.txReady;
        rxValid = v.rxValid;
        rxData  = v.rxData;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Collects one frame starting at the tag; in stall mode iTxReady alternates 0/1.
    task automatic receiveFrame(input string name, input logic [7:0] tag,
                                input logic [39:0] val, input bit stall);
        int waitCnt = 0;
        int k = 0;
        int cyc = 0;
        logic [7:0] expByte;
        while (!txValid && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!txValid) begin
            checkOutput({name, ".start"}, 64'd0, 64'd1);
            return;
        end
        while (k < 6 && cyc < 40) begin
            expByte = (k == 0) ? tag : val[8*(5-k) +: 8];
            checkOutput($sformatf("%s.valid%0d", name, cyc), {63'd0, txValid}, 64'd1);
            checkOutput($sformatf("%s.byte%0d", name, k), {56'd0, txData}, {56'd0, expByte});
            txReady = stall ? (cyc % 2 == 1) : 1'b1;
            if (txReady) k++;
            cyc++;
            @(negedge clk);
        end
        txReady = 1'b1;
        checkOutput({name, ".complete"}, 64'(k), 64'd6);
        checkOutput({name, ".endValid"}, {63'd0, txValid}, 64'd0);
        checkOutput({name, ".endBusy"}, {63'd0, busy}, 64'd1);
    endtask

    task automatic sendAck(input logic [7:0] b);
        rxValid = 1'b1;
        rxData  = b;
        @(negedge clk);
        rxValid = 1'b0;
    endtask

    task automatic checkPulse(input string name, input int ch);
        int cnt = 0;
        int other = 0;
        for (int i = 0; i < 20; i++) begin
            if ((ch == 1 ? latch1 : latch2) !== 1'b1) break;
            if ((ch == 1 ? latch2 : latch1) !== 1'b0) other++;
            cnt++;
            @(negedge clk);
        end
        checkOutput({name, ".width"}, 64'(cnt), 64'd4);
        checkOutput({name, ".other"}, 64'(other), 64'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int gap;
        int sawLatch;

        rstN = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0; txReady = 1'b1;
        rxValid = 1'b0; rxData = 8'h00;
        counter1 = 40'h12_3456_789A;
        counter2 = 40'h01_0203_0405;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h34, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h56, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h78, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h9A, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        checkOutput("rst.txValid", {63'd0, txValid}, 64'd0);
        checkOutput("rst.busy", {63'd0, busy}, 64'd0);
        checkOutput("rst.errCount", {56'd0, errCount}, 64'd0);
        checkOutput("rst.rxReady", {63'd0, rxReady}, 64'd0);
        checkOutput("rst.latches", {62'd0, latch1, latch2}, 64'd0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("post.rxReady", {63'd0, rxReady}, 64'd1);

        $display("[TB] channel 1 frame, ack, pulse, no resend");
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d.valid", i), {63'd0, txValid}, {63'd0, vecs[i].expValid});
            if (vecs[i].expValid)
                checkOutput($sformatf("vec%0d.data", i), {56'd0, txData}, {56'd0, vecs[i].expData});
            checkOutput($sformatf("vec%0d.latch1", i), {63'd0, latch1}, {63'd0, vecs[i].expL1});
            checkOutput($sformatf("vec%0d.latch2", i), {63'd0, latch2}, {63'd0, vecs[i].expL2});
            checkOutput($sformatf("vec%0d.busy", i), {63'd0, busy}, {63'd0, vecs[i].expBusy});
        end

        $display("[TB] channel 2 frame with stalls");
        rdy1 = 1'b0;
        repeat (5) @(negedge clk);
        rdy2 = 1'b1;
        receiveFrame("stall", 8'h01, 40'h01_0203_0405, 1'b1);
        sendAck(8'h01);
        checkPulse("stallPulse", 2);
        rdy2 = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] simultaneous Rdy arbitration");
        counter1 = 40'hA1_A2A3_A4A5;
        counter2 = 40'hB1_B2B3_B4B5;
        rdy1 = 1'b1;
        rdy2 = 1'b1;
        receiveFrame("tie1", 8'h00, 40'hA1_A2A3_A4A5, 1'b0);
        sendAck(8'h00);
        checkPulse("tie1Pulse", 1);
        receiveFrame("tie2", 8'h01, 40'hB1_B2B3_B4B5, 1'b0);
        sendAck(8'h01);
        checkPulse("tie2Pulse", 2);
        rdy1 = 1'b0;
        repeat (4) @(negedge clk);
        counter1 = 40'h55_6677_8899;
        rdy1 = 1'b1;
        receiveFrame("again1", 8'h00, 40'h55_6677_8899, 1'b0);
        sendAck(8'h00);
        checkPulse("again1Pulse", 1);
        checkOutput("tie.errCount", {56'd0, errCount}, 64'd0);

        $display("[TB] ack timeout and wrong tag");
        rdy1 = 1'b0;
        rdy2 = 1'b0;
        repeat (5) @(negedge clk);
        counter1 = 40'hC1_C2C3_C4C5;
        rdy1 = 1'b1;
        receiveFrame("tmo", 8'h00, 40'hC1_C2C3_C4C5, 1'b0);
        gap = 0;
        sawLatch = 0;
        while (!txValid && gap < 40) begin
            rxValid = (gap == 2);
            rxData  = 8'h01;
            if (latch1 || latch2) sawLatch++;
            gap++;
            @(negedge clk);
        end
        rxValid = 1'b0;
        checkOutput("tmo.gap", 64'(gap), 64'd16);
        checkOutput("tmo.noPulse", 64'(sawLatch), 64'd0);
        checkOutput("tmo.errCount", {56'd0, errCount}, 64'd1);
        receiveFrame("resend", 8'h00, 40'hC1_C2C3_C4C5, 1'b0);
        sendAck(8'h00);
        checkPulse("resendPulse", 1);
        checkOutput("resend.errCount", {56'd0, errCount}, 64'd1);

        $display("[TB] reset mid-frame");
        rdy1 = 1'b0;
        repeat (5) @(negedge clk);
        counter1 = 40'hD1_D2D3_D4D5;
        rdy1 = 1'b1;
        gap = 0;
        while (!txValid && gap < 50) begin
            @(negedge clk);
            gap++;
        end
        checkOutput("mid.tag", {56'd0, txData}, 64'h00);
        @(negedge clk);
        checkOutput("mid.b1", {56'd0, txData}, 64'hD1);
        @(negedge clk);
        checkOutput("mid.b2", {56'd0, txData}, 64'hD2);
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("mid.txValid", {63'd0, txValid}, 64'd0);
        checkOutput("mid.busy", {63'd0, busy}, 64'd0);
        checkOutput("mid.errCount", {56'd0, errCount}, 64'd0);
        rstN = 1'b1;
        receiveFrame("restart", 8'h00, 40'hD1_D2D3_D4D5, 1'b0);
        sendAck(8'h00);
        checkPulse("restartPulse", 1);

        $display("[TB] stray rx bytes saturate the error count");
        rdy1 = 1'b0;
        repeat (3) @(negedge clk);
        rxData  = 8'h5A;
        rxValid = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("sat.200", {56'd0, errCount}, 64'd200);
        repeat (100) @(negedge clk);
        rxValid = 1'b0;
        checkOutput("sat.300", {56'd0, errCount}, 64'hFF);
        checkOutput("sat.busy", {63'd0, busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
